debounce_det: RTL and testbench

// - Switch/button debouncer with two outputs from one sampled input: delayed and early.
// - Delayed output changes only after the input is stable for the debounce window.
// - Early output follows the first input edge at once, then ignores the input for the window.
// - Sits between a raw mechanical switch pin and synchronous control logic.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_tick.sv | 22 ++
 rtl/debounce_det.sv | 157 +++++++++++++++
 tb/tb_debounce_det.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared state set and defaults for the switch debouncer.
// A wait state is qualified by a separate tick index so the window length scales freely.
package debounce_pkg;

  typedef enum logic [1:0] {
    StZero,
    StWait1,
    StOne,
    StWait0
  } db_state_t;

  localparam int unsigned DefN          = 19;
  localparam int unsigned DefWaitTicks  = 3;
  localparam int unsigned DefSyncStages = 2;

  function automatic int unsigned idx_width(input int unsigned ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/debounce_tick.sv
// Free-running N-bit counter; tick pulses for one cycle each time it reaches all-ones.
module debounce_tick #(
  parameter int unsigned N = 19
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [N-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + N'(1);
    end
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/debounce_det.sv
// Switch debouncer: one synchronized input feeds a delayed-scheme and an early-scheme FSM,
// both paced by a shared tick that is never restarted by switch activity.
module debounce_det
  import debounce_pkg::*;
#(
  parameter int unsigned N           = DefN,
  parameter int unsigned WAIT_TICKS  = DefWaitTicks,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db_delay,
  output logic db_early
);

  localparam int unsigned    IdxW    = idx_width(WAIT_TICKS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WAIT_TICKS - 1);

  logic sw_s;
  logic tick;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign sw_s = sw;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= sw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign sw_s = sync_q[SYNC_STAGES-1];
  end

  debounce_tick #(
    .N (N)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  db_state_t       dl_state_q, el_state_q;
  logic [IdxW-1:0] dl_idx_q, el_idx_q;
  logic            db_delay_q, db_early_q;

  // Delayed scheme: a revert of sw_s aborts the window and takes priority over a same-cycle tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_state_q <= StZero;
      dl_idx_q   <= '0;
      db_delay_q <= 1'b0;
    end else begin
      unique case (dl_state_q)
        StZero: begin
          if (sw_s) begin
            dl_state_q <= StWait1;
            dl_idx_q   <= '0;
          end
        end
        StWait1: begin
          if (!sw_s) begin
            dl_state_q <= StZero;
          end else if (tick) begin
            if (dl_idx_q == LastIdx) begin
              dl_state_q <= StOne;
              db_delay_q <= 1'b1;
            end else begin
              dl_idx_q <= dl_idx_q + IdxW'(1);
            end
          end
        end
        StOne: begin
          if (!sw_s) begin
            dl_state_q <= StWait0;
            dl_idx_q   <= '0;
          end
        end
        StWait0: begin
          if (sw_s) begin
            dl_state_q <= StOne;
          end else if (tick) begin
            if (dl_idx_q == LastIdx) begin
              dl_state_q <= StZero;
              db_delay_q <= 1'b0;
            end else begin
              dl_idx_q <= dl_idx_q + IdxW'(1);
            end
          end
        end
        default: begin
          dl_state_q <= StZero;
          db_delay_q <= 1'b0;
        end
      endcase
    end
  end

  // Early scheme: the output flips on entry to a window; sw_s is ignored until it expires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      el_state_q <= StZero;
      el_idx_q   <= '0;
      db_early_q <= 1'b0;
    end else begin
      unique case (el_state_q)
        StZero: begin
          if (sw_s) begin
            el_state_q <= StWait1;
            el_idx_q   <= '0;
            db_early_q <= 1'b1;
          end
        end
        StWait1: begin
          if (tick) begin
            if (el_idx_q == LastIdx) begin
              el_state_q <= StOne;
            end else begin
              el_idx_q <= el_idx_q + IdxW'(1);
            end
          end
        end
        StOne: begin
          if (!sw_s) begin
            el_state_q <= StWait0;
            el_idx_q   <= '0;
            db_early_q <= 1'b0;
          end
        end
        StWait0: begin
          if (tick) begin
            if (el_idx_q == LastIdx) begin
              el_state_q <= StZero;
            end else begin
              el_idx_q <= el_idx_q + IdxW'(1);
            end
          end
        end
        default: begin
          el_state_q <= StZero;
          db_early_q <= 1'b0;
        end
      endcase
    end
  end

  assign db_delay = db_delay_q;
  assign db_early = db_early_q;

endmodule

// File: tb/tb_debounce_det.sv
// Scoreboard bench for debounce_det: a level/window reference model predicts both outputs
// every cycle, and a monitor compares them on the falling edge.
module tb_debounce_det;

  localparam int unsigned N          = 4;
  localparam int unsigned WaitTicks  = 3;
  localparam int unsigned SyncStages = 2;
  localparam int unsigned TickPeriod = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sw  = 1'b0;
  logic db_delay, db_early;

  int checks   = 0;
  int failures = 0;

  debounce_det #(
    .N           (N),
    .WAIT_TICKS  (WaitTicks),
    .SYNC_STAGES (SyncStages)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .db_delay (db_delay),
    .db_early (db_early)
  );

  always #10 clk = ~clk;

  // Reference model: each output is a level plus an optional open window counted in ticks.
  logic        sync_m [SyncStages];
  int unsigned cnt_m;
  logic        od, oe;
  bit          dwin, ebusy;
  int unsigned dcnt, ecnt;
  logic [1:0]  exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < SyncStages; i++) sync_m[i] = 1'b0;
    cnt_m = 0;
    od = 1'b0; oe = 1'b0;
    dwin = 0; ebusy = 0;
    dcnt = 0; ecnt = 0;
  endtask

  task automatic model_edge(input logic v);
    logic s;
    bit   t;
    s = sync_m[SyncStages-1];
    t = (cnt_m == TickPeriod - 1);
    // Delayed: level changes only after sw_s has differed from it for a full window.
    if (!dwin) begin
      if (s != od) begin dwin = 1; dcnt = 0; end
    end else if (s == od) begin
      dwin = 0;
    end else if (t) begin
      dcnt++;
      if (dcnt == WaitTicks) begin od = ~od; dwin = 0; end
    end
    // Early: level follows sw_s at once, then is frozen for a window.
    if (!ebusy) begin
      if (s != oe) begin oe = s; ebusy = 1; ecnt = 0; end
    end else if (t) begin
      ecnt++;
      if (ecnt == WaitTicks) ebusy = 0;
    end
    for (int i = SyncStages - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
    sync_m[0] = v;
    cnt_m = (cnt_m + 1) % TickPeriod;
  endtask

  task automatic step(input logic v);
    sw = v;
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge(v);
    exp_q.push_back({od, oe});
    @(negedge clk);
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  // Monitor: one expected pair per clock, compared away from the rising edge.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({db_delay, db_early} !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got delay=%b early=%b expected delay=%b early=%b",
                   $time, db_delay, db_early, e[1], e[0]);
        end
      end
    end
  end

  initial begin
    model_reset();
    // Reset for one cycle, then idle.
    step(1'b0);
    rst = 1'b1;
    hold(1'b0, 40);
    // Bouncing rise then settle high.
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    hold(1'b1, 80);
    // Settled high, then a fall with a single-cycle glitch.
    hold(1'b1, 100);
    hold(1'b0, 4);
    step(1'b1);
    hold(1'b0, 120);
    // Short glitch from ZERO.
    hold(1'b1, 5);
    hold(1'b0, 120);
    // Asynchronous reset while both schemes are inside a rising window.
    hold(1'b1, 8);
    #3 rst = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    checks++;
    if (db_delay !== 1'b0 || db_early !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got delay=%b early=%b expected delay=0 early=0",
               db_delay, db_early);
    end
    hold(1'b1, 2);
    @(negedge clk);
    rst = 1'b1;
    // Revert reaches sw_s exactly on the final tick of the rising window.
    hold(1'b1, 45);
    hold(1'b0, 60);
    // Random bursts mixing long holds and short bounces.
    for (int b = 0; b < 40; b++) begin
      logic lvl;
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) hold(lvl, $urandom_range(1, 4));
      else                           hold(lvl, $urandom_range(10, 70));
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
